// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered BCD/hex word, one digit lit
// per slot with a dead-time cycle, optional hex glyphs and leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pendVal;
  logic [DIGITS-1:0]   pendDp;
  logic                pendFlag;
  logic [4*DIGITS-1:0] dispVal;
  logic [DIGITS-1:0]   dispDp;
  logic                ranFrame;

  logic                slotEnd;
  logic                frameWrap;
  logic [DIGITS-1:0]   lzMask;
  logic                upperZero;
  logic [3:0]          curNib;
  logic                curDp;
  logic                curBlank;
  logic [DIGITS-1:0]   anSel;
  logic [6:0]          segNext;
  logic                dpNext;
  logic [DIGITS-1:0]   anNext;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = hex ? 7'b1110111 : 7'b0000000;
      4'hB: g = hex ? 7'b0011111 : 7'b0000000;
      4'hC: g = hex ? 7'b1001110 : 7'b0000000;
      4'hD: g = hex ? 7'b0111101 : 7'b0000000;
      4'hE: g = hex ? 7'b1001111 : 7'b0000000;
      default: g = hex ? 7'b1000111 : 7'b0000000;
    endcase
    return g;
  endfunction

  assign slotEnd   = (presc == PRESC_LAST);
  assign frameWrap = slotEnd && (idx == IDX_LAST);

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    lzMask    = '0;
    upperZero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upperZero = upperZero && (dispVal[i*4 +: 4] == 4'h0);
      lzMask[i] = blank_lz && upperZero && (i != 0);
    end
  end

  always_comb begin
    curNib   = '0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    anSel    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        curNib   = dispVal[i*4 +: 4];
        curDp    = dispDp[i];
        curBlank = lzMask[i];
        anSel[i] = 1'b1;
      end
    end
    if (presc == '0) begin
      segNext = 7'h00;
      dpNext  = 1'b0;
      anNext  = '0;
    end else begin
      segNext = curBlank ? 7'h00 : decode(curNib, hex_mode);
      dpNext  = curDp;
      anNext  = anSel;
    end
  end

  // Display buffer only changes on the frame-wrap cycle so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      pendVal    <= '0;
      pendDp     <= '0;
      pendFlag   <= 1'b0;
      dispVal    <= '0;
      dispDp     <= '0;
      ranFrame   <= 1'b0;
      seg        <= SEG_POL;
      dp         <= DP_POL;
      an         <= AN_POL;
      frame_done <= 1'b0;
    end else begin
      presc <= slotEnd ? '0 : presc + 1'b1;
      if (slotEnd) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (frameWrap) begin
        ranFrame <= 1'b1;
        pendFlag <= 1'b0;
        if (load) begin
          dispVal <= value;
          dispDp  <= dp_in;
        end else if (pendFlag) begin
          dispVal <= pendVal;
          dispDp  <= pendDp;
        end
      end else if (load) begin
        pendVal  <= value;
        pendDp   <= dp_in;
        pendFlag <= 1'b1;
      end
      seg        <= segNext ^ SEG_POL;
      dp         <= dpNext ^ DP_POL;
      an         <= anNext ^ AN_POL;
      frame_done <= (presc == '0) && (idx == '0) && ranFrame;
    end
  end

endmodule
